// File: rtl/grf_writeback_sink.sv
// grf_writeback_sink: 32x32 register file fed by W stage, with commit trace and write counter.
// Optional GRF_BYPASS_EN enables same-cycle write-to-read forwarding.
module grf_writeback_sink #(
  parameter int          NREG     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] W_PC,
  input  logic        regw_enable,
  input  logic [4:0]  regw_adr,
  input  logic [31:0] reg_write,
  input  logic [4:0]  rs_adr,
  input  logic [4:0]  rt_adr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic        commit_valid,
  output logic [31:0] commit_pc,
  output logic [4:0]  commit_adr,
  output logic [31:0] commit_data,
  output logic [31:0] write_count
);

  logic [31:0] regs [NREG];
  logic        we_eff;

  assign we_eff = regw_enable && (regw_adr != 5'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we_eff) begin
      regs[regw_adr] <= reg_write;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      commit_valid <= 1'b0;
      commit_pc    <= RESET_PC;
      commit_adr   <= 5'd0;
      commit_data  <= '0;
      write_count  <= '0;
    end else begin
      commit_valid <= we_eff;
      if (we_eff) begin
        commit_pc   <= W_PC;
        commit_adr  <= regw_adr;
        commit_data <= reg_write;
        write_count <= write_count + 32'd1;
      end
    end
  end

  // $0 is never stored, so reads of it are forced to zero here.
  always_comb begin
    rs_data = (rs_adr == 5'd0) ? 32'h0 : regs[rs_adr];
    rt_data = (rt_adr == 5'd0) ? 32'h0 : regs[rt_adr];
`ifdef GRF_BYPASS_EN
    if (reset && we_eff && (regw_adr == rs_adr)) rs_data = reg_write;
    if (reset && we_eff && (regw_adr == rt_adr)) rt_data = reg_write;
`endif
  end

endmodule

// File: tb/tb_grf_writeback_sink.sv
// Scoreboard bench for grf_writeback_sink: random writes/reads against an array model.
// Commit pulses are checked by a monitor popping an expected-commit queue.
module tb_grf_writeback_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] W_PC;
  logic        regw_enable;
  logic [4:0]  regw_adr;
  logic [31:0] reg_write;
  logic [4:0]  rs_adr;
  logic [4:0]  rt_adr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [4:0]  commit_adr;
  logic [31:0] commit_data;
  logic [31:0] write_count;

  grf_writeback_sink dut (
    .clk(clk), .reset(reset), .W_PC(W_PC),
    .regw_enable(regw_enable), .regw_adr(regw_adr),
    .reg_write(reg_write), .rs_adr(rs_adr), .rt_adr(rt_adr),
    .rs_data(rs_data), .rt_data(rt_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_adr(commit_adr), .commit_data(commit_data),
    .write_count(write_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  adr;
    logic [31:0] data;
  } rec_t;

  rec_t        exp_q[$];
  logic [31:0] mdl [32];
  int unsigned m_cnt;
  bit          started;
  int          n_checks;
  int          n_fail;

`ifdef GRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (BYP && reset && regw_enable && regw_adr == a) return reg_write;
    return mdl[a];
  endfunction

  // One clock: drive at negedge, check reads before the edge, update model at the edge.
  task automatic cyc(input logic rst, input logic en, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [31:0] pc,
                     input logic [4:0] ra, input logic [4:0] rb);
    @(negedge clk);
    reset = rst; regw_enable = en; regw_adr = wa;
    reg_write = wd; W_PC = pc; rs_adr = ra; rt_adr = rb;
    #1;
    if (started) begin
      chk("rs_pre_edge", rs_data, exp_read(ra));
      chk("rt_pre_edge", rt_data, exp_read(rb));
    end
    @(posedge clk);
    if (!rst) begin
      foreach (mdl[i]) mdl[i] = 32'h0;
      m_cnt = 0;
      started = 1'b1;
    end else if (en && wa != 0) begin
      mdl[wa] = wd;
      m_cnt++;
      exp_q.push_back('{pc: pc, adr: wa, data: wd});
    end
    #1;
    regw_enable = 1'b0;
    regw_adr = 5'd0;
  endtask

  task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] exp);
    rs_adr = a;
    #1;
    chk(nm, rs_data, exp);
  endtask

  // Monitor: each commit pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (started) chk("write_count", write_count, m_cnt);
    if (commit_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL commit_unexpected: got adr %0d data %h expected no pulse",
                 commit_adr, commit_data);
      end else begin
        rec_t r;
        r = exp_q.pop_front();
        chk("commit_pc", commit_pc, r.pc);
        chk("commit_adr", commit_adr, r.adr);
        chk("commit_data", commit_data, r.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; regw_enable = 1'b0; regw_adr = 0;
    reg_write = 0; W_PC = 0; rs_adr = 0; rt_adr = 0;
    n_checks = 0; n_fail = 0; m_cnt = 0; started = 1'b0;

    // Reset, with a write presented that must be discarded
    cyc(1'b0, 1'b1, 5'd5, 32'hAAAA_AAAA, 32'h3004, 5'd5, 5'd31);
    cyc(1'b0, 1'b1, 5'd5, 32'hAAAA_AAAA, 32'h3004, 5'd5, 5'd31);
    chk("rst_commit_valid", {31'b0, commit_valid}, 32'd0);
    chk("rst_commit_pc", commit_pc, 32'h3000);
    chk("rst_commit_adr", {27'b0, commit_adr}, 32'd0);
    chk("rst_commit_data", commit_data, 32'd0);
    chk("rst_write_count", write_count, 32'd0);
    reset = 1'b1;
    rt_adr = 5'd31;
    rd("rst_read_rs5", 5'd5, 32'h0);
    chk("rst_read_rt31", rt_data, 32'h0);

    // Basic write
    cyc(1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF, 32'h3010, 5'd0, 5'd0);
    chk("basic_commit_valid", {31'b0, commit_valid}, 32'd1);
    chk("basic_commit_pc", commit_pc, 32'h3010);
    chk("basic_commit_adr", {27'b0, commit_adr}, 32'd8);
    chk("basic_commit_data", commit_data, 32'hDEAD_BEEF);
    chk("basic_write_count", write_count, 32'd1);
    rd("basic_read8", 5'd8, 32'hDEAD_BEEF);

    // $0 write is ignored
    cyc(1'b1, 1'b1, 5'd0, 32'h1234, 32'h3014, 5'd0, 5'd0);
    chk("zero_commit_valid", {31'b0, commit_valid}, 32'd0);
    chk("zero_write_count", write_count, 32'd1);
    rd("zero_read0", 5'd0, 32'h0);

    // Same-cycle read of the register being written
    cyc(1'b1, 1'b1, 5'd9, 32'h11, 32'h3018, 5'd0, 5'd0);
    cyc(1'b1, 1'b1, 5'd9, 32'h22, 32'h301c, 5'd9, 5'd9);
    rd("same_cycle_after", 5'd9, 32'h22);

    // Back-to-back writes from a fresh reset, then reset mid-stream
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    cyc(1'b1, 1'b1, 5'd3, 32'd1, 32'h3100, 5'd3, 5'd4);
    chk("b2b_valid1", {31'b0, commit_valid}, 32'd1);
    cyc(1'b1, 1'b1, 5'd3, 32'd2, 32'h3104, 5'd3, 5'd4);
    chk("b2b_valid2", {31'b0, commit_valid}, 32'd1);
    cyc(1'b1, 1'b1, 5'd4, 32'd3, 32'h3108, 5'd3, 5'd4);
    chk("b2b_valid3", {31'b0, commit_valid}, 32'd1);
    chk("b2b_write_count", write_count, 32'd3);
    rd("b2b_read3", 5'd3, 32'd2);
    cyc(1'b0, 1'b1, 5'd5, 32'd7, 32'h310c, 5'd5, 5'd3);
    chk("mid_rst_write_count", write_count, 32'd0);
    chk("mid_rst_commit_valid", {31'b0, commit_valid}, 32'd0);
    rd("mid_rst_read5", 5'd5, 32'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd3);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      logic        r, e;
      logic [4:0]  wa, ra, rb;
      r  = ($urandom_range(0, 39) != 0);
      e  = ($urandom_range(0, 9) < 7);
      wa = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      cyc(r, e, wa, $urandom, $urandom, ra, rb);
    end
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 5'd1, 5'd2);
    @(negedge clk);
    #1;
    chk("commit_q_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
